conv_job_sequencer: RTL

- Job-level controller in front of the 3x3 XNOR convolution engine.
- Buffers host job descriptors (input, output and weight SRAM base addresses) in a small FIFO and launches the engine once per job with a single-cycle run pulse.
- While a job runs, it relocates the engine's local SRAM and WMEM addresses by the active job's bases and gates the engine's write enable.
- Tracks completion, counts finished jobs and halts on an engine hang (watchdog).

---
 rtl/conv_job_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/conv_job_sequencer.sv
// rtl/conv_job_sequencer.sv - job FIFO, launch FSM, address relocation and watchdog for the XNOR conv engine
module conv_job_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int START_TO   = 16,
  parameter int RUN_TO     = 4096
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_base,
  input  logic [ADDR_W-1:0] job_out_base,
  input  logic [ADDR_W-1:0] job_w_base,
  output logic              eng_run,
  input  logic              eng_busy,
  input  logic [ADDR_W-1:0] eng_sram_read_address,
  input  logic [ADDR_W-1:0] eng_sram_write_address,
  input  logic              eng_sram_write_enable,
  input  logic [ADDR_W-1:0] eng_wmem_read_address,
  output logic [ADDR_W-1:0] sram_read_address,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] wmem_read_address,
  output logic              seq_busy,
  output logic              job_done,
  output logic [7:0]        jobs_done_cnt,
  output logic              timeout_err,
  input  logic              clear_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WD_MAX = (RUN_TO > START_TO) ? RUN_TO : START_TO;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  logic [3*ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  logic [2:0]          state;
  logic [ADDR_W-1:0]   in_base;
  logic [ADDR_W-1:0]   out_base;
  logic [ADDR_W-1:0]   w_base;
  logic [WD_W-1:0]     wdog;
  logic [WD_W-1:0]     wdog_inc;

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot early.
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign job_ready = ~full;
  assign push      = job_valid & ~full;
  assign pop       = (state == S_IDLE) & ~empty;
  assign wdog_inc  = wdog + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {job_in_base, job_out_base, job_w_base};
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= S_IDLE;
      in_base       <= '0;
      out_base      <= '0;
      w_base        <= '0;
      wdog          <= '0;
      timeout_err   <= 1'b0;
      jobs_done_cnt <= 8'd0;
    end else begin
      if (clear_err) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {in_base, out_base, w_base} <= fifo_mem[rd_ptr];
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wdog  <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (eng_busy) begin
            wdog  <= '0;
            state <= S_RUN;
          end else if (wdog_inc == WD_W'(START_TO)) begin
            timeout_err <= 1'b1;
            state       <= S_HALT;
          end else begin
            wdog <= wdog_inc;
          end
        end
        S_RUN: begin
          if (!eng_busy) begin
            state <= S_DONE;
          end else if (wdog_inc == WD_W'(RUN_TO)) begin
            timeout_err <= 1'b1;
            state       <= S_HALT;
          end else begin
            wdog <= wdog_inc;
          end
        end
        S_DONE: begin
          jobs_done_cnt <= jobs_done_cnt + 8'd1;
          state         <= S_IDLE;
        end
        S_HALT: begin
          // The aborted job is discarded; queued jobs resume after the host acknowledges.
          if (clear_err) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      eng_run  <= 1'b0;
      job_done <= 1'b0;
    end else begin
      eng_run  <= (state == S_LAUNCH);
      job_done <= (state == S_DONE);
    end
  end

  assign sram_read_address  = in_base + eng_sram_read_address;
  assign sram_write_address = out_base + eng_sram_write_address;
  assign wmem_read_address  = w_base + eng_wmem_read_address;
  assign sram_write_enable  = eng_sram_write_enable &
                              ((state == S_WAIT_BUSY) | (state == S_RUN) | (state == S_DONE));
  assign seq_busy           = (state != S_IDLE) | ~empty;

endmodule
